// File: rtl/carry_resolver.sv
// Resolves a split-segment adder's redundant result by rippling segment carries one hop per clock.
// Optional RESOLVE step counter output out_iters enabled by `define CARRY_RESOLVER_ITER_COUNT_EN.
module carry_resolver #(
  parameter int IO = 16,
  parameter int SS = 4,
  localparam int N_PARTS = IO / SS + (((IO % SS) != 0) ? 1 : 0)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IO-1:0]      in_sum,
  input  logic [N_PARTS-1:0] in_cout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IO-1:0]      out_value,
  output logic               out_carry
`ifdef CARRY_RESOLVER_ITER_COUNT_EN
  ,
  output logic [$clog2(N_PARTS):0] out_iters
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [IO-1:0]        value_r;
  logic [IO-1:0]        step_value_s;
  logic                 ovf_r;
  logic [N_PARTS-1:1]   pend_r;
  logic [N_PARTS-1:1]   pend_next_s;
  logic                 top_carry_s;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic                 accept_s;

  assign accept_s  = in_valid && in_ready_r;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_value = value_r;
  assign out_carry = ovf_r;

  // Segment 0 never receives a pending carry; it passes through each step unchanged.
  assign step_value_s[SS-1:0] = value_r[SS-1:0];
  assign pend_next_s[1]       = 1'b0;

  for (genvar k = 1; k < N_PARTS; k++) begin : g_seg
    localparam int LO = k * SS;
    localparam int W  = ((k == N_PARTS - 1) && ((IO % SS) != 0)) ? (IO % SS) : SS;
    logic [W:0] seg_sum_s;

    assign seg_sum_s = {1'b0, value_r[LO+W-1:LO]} + {{W{1'b0}}, pend_r[k]};
    assign step_value_s[LO+W-1:LO] = seg_sum_s[W-1:0];

    // A narrow top segment overflows at bit IO-1, which is seg_sum_s[W] here.
    if (k < N_PARTS - 1) begin : g_mid
      assign pend_next_s[k+1] = seg_sum_s[W];
    end else begin : g_top
      assign top_carry_s = seg_sum_s[W];
    end
  end

  // Next-state decode for the IDLE/RESOLVE/DONE control FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (in_cout[N_PARTS-2:0] == {(N_PARTS-1){1'b0}}) begin
            state_next_s = DONE;
          end else begin
            state_next_s = RESOLVE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      RESOLVE: begin
        if (pend_next_s == {(N_PARTS-1){1'b0}}) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RESOLVE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, handshake flags and the resolving datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      value_r     <= {IO{1'b0}};
      ovf_r       <= 1'b0;
      pend_r      <= {(N_PARTS-1){1'b0}};
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            value_r <= in_sum;
            ovf_r   <= in_cout[N_PARTS-1];
            pend_r  <= in_cout[N_PARTS-2:0];
          end
        end
        RESOLVE: begin
          value_r <= step_value_s;
          pend_r  <= pend_next_s;
          ovf_r   <= ovf_r | top_carry_s;
        end
        DONE: begin
          value_r <= value_r;
        end
        default: begin
          pend_r <= {(N_PARTS-1){1'b0}};
        end
      endcase
    end
  end

`ifdef CARRY_RESOLVER_ITER_COUNT_EN
  logic [$clog2(N_PARTS):0] iters_r;

  assign out_iters = iters_r;

  // Counts RESOLVE steps for the current result; held through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iters_r <= {($clog2(N_PARTS)+1){1'b0}};
    end else if ((state_r == IDLE) && accept_s) begin
      iters_r <= {($clog2(N_PARTS)+1){1'b0}};
    end else if (state_r == RESOLVE) begin
      iters_r <= iters_r + {{$clog2(N_PARTS){1'b0}}, 1'b1};
    end else begin
      iters_r <= iters_r;
    end
  end
`endif

endmodule

// File: doc/carry_resolver.md
Name: carry_resolver

Overview:
- Downstream of the split-segment adder. Consumes its redundant result: a segmented sum plus one carry-out bit per segment.
- Ripples the pending segment carries forward, one segment hop per clock, until no carry remains.
- Emits the fully resolved IO-bit value and a final overflow bit over a valid/ready handshake.
- Lets the adder stay short-path combinational; carry propagation is paid in cycles only when carries exist.

Parameters:
- IO, 16, operand width in bits; must match the upstream adder.
- SS, 4, segment size in bits; must match the upstream adder. Top segment is IO%SS bits wide when IO%SS≠0.
- N_PARTS (localparam), IO/SS + (IO%SS?1:0), number of segments = width of the carry vector.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream result valid
- in_ready  out  1  block can accept
- in_sum  in  IO  segmented sum from the adder
- in_cout  in  N_PARTS  carry-out of each segment; bit k carries into segment k+1
- out_valid  out  1  resolved result available
- out_ready  in  1  downstream accepts
- out_value  out  IO  resolved value, low IO bits
- out_carry  out  1  overflow out of bit IO-1

Behaviour:
- Input semantics: value = in_sum + Σ in_cout[k]·2^((k+1)·SS). Outputs satisfy {out_carry,out_value} = value; value < 2^(IO+1) is guaranteed upstream.
- Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, out_value=0, out_carry=0, internal carry vector=0.
- FSM IDLE:
  - in_ready=1. Accept on in_valid&&in_ready.
  - On accept: value_reg<=in_sum; ovf<=in_cout[N_PARTS-1]; pend<=in_cout[N_PARTS-2:0] placed at segments 1..N_PARTS-1.
  - Next state DONE if in_cout[N_PARTS-2:0]==0, else RESOLVE.
- FSM RESOLVE:
  - in_ready=0. Each cycle every segment k≥1 computes seg_k + pend_k in parallel.
  - Carry-out of segment k becomes pend_{k+1}. Carry-out of the top segment ORs into ovf.
  - Go to DONE the cycle after the step whose new pend is all-zero.
  - Takes at most N_PARTS-1 steps.
- FSM DONE:
  - out_valid=1; out_value/out_carry stable while out_ready=0.
  - On out_ready: out_valid drops next cycle, state IDLE.
  - No same-cycle accept in DONE (in_ready=0).
- Latency: accept → out_valid = 1 cycle with no internal carries, else 1+steps cycles. Throughput: one result per (latency+1) cycles minimum.
- Top segment narrower than SS: its carry-out is taken at bit IO-1.
- in_valid while busy: ignored, not latched.
- Reset mid-RESOLVE or mid-DONE: immediate return to the reset values; the in-flight result is discarded.

Optional Feature:
- Macro: CARRY_RESOLVER_ITER_COUNT_EN.
- Defined:
  - Adds output out_iters, width $clog2(N_PARTS)+1. It holds the number of RESOLVE steps used for the current result.
  - Cleared on accept, incremented per RESOLVE cycle, held through DONE. Reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan (IO=16, SS=4 unless noted):
- in_sum=0x1234, in_cout=0b0000 → out_valid 1 cycle after accept, out_value=0x1234, out_carry=0, iters=0.
- in_sum=0xFFFF, in_cout=0b0001 → 3 RESOLVE steps, out_value=0x000F, out_carry=1, iters=3, out_valid 4 cycles after accept.
- in_sum=0x0F0F, in_cout=0b0101 → 1 step, out_value=0x1F1F, out_carry=0, iters=1.
- in_sum=0x0001, in_cout=0b1000 → no steps, out_value=0x0001, out_carry=1; hold out_ready=0 for 5 cycles → outputs stable, in_ready=0, extra in_valid ignored.
- IO=10, SS=4 (N_PARTS=3): in_sum=0x3FF, in_cout=0b001 → out_value=0x00F, out_carry=1, iters=2.
- Assert rst_n=0 during RESOLVE of the 0xFFFF case → outputs zero asynchronously; after release in_ready=1, next transaction correct.
